// File: rtl/hazard_scoreboard_if.sv
// ID-stage issue bus into the hazard scoreboard; the scoreboard answers with a combinational stall.
// master = ID stage driving the decoded instruction, slave = scoreboard.
interface hazard_scoreboard_if #(
  parameter int REG_NUM_WIDTH = 5,
  parameter int CNT_WIDTH     = 3
);
  logic                     issue_valid;
  logic                     issue_wr_en;
  logic [REG_NUM_WIDTH-1:0] issue_dst;
  logic [CNT_WIDTH-1:0]     issue_lat;
  logic [REG_NUM_WIDTH-1:0] src_a;
  logic [REG_NUM_WIDTH-1:0] src_b;
  logic                     src_a_used;
  logic                     src_b_used;
  logic                     stall;

  modport master (
    output issue_valid, issue_wr_en, issue_dst, issue_lat,
    output src_a, src_b, src_a_used, src_b_used,
    input  stall
  );

  modport slave (
    input  issue_valid, issue_wr_en, issue_dst, issue_lat,
    input  src_a, src_b, src_a_used, src_b_used,
    output stall
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard: stall is combinational from current counts, counts update each edge.
// Freeze holds every count; define SB_STATS_EN to add saturating stall_cycles/issue_count outputs.
module hazard_scoreboard #(
  parameter int REG_NUM_WIDTH = 5,
  parameter int NUM_REGS      = 2 ** REG_NUM_WIDTH,
  parameter int CNT_WIDTH     = 3
`ifdef SB_STATS_EN
  ,
  parameter int STAT_WIDTH    = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  hazard_scoreboard_if.slave    sb,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic                  any_busy
`ifdef SB_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stall_cycles,
  output logic [STAT_WIDTH-1:0] issue_count
`endif
);

  logic [CNT_WIDTH-1:0] cnt [NUM_REGS];
  logic [CNT_WIDTH-1:0] dec [NUM_REGS];
  logic                 src_a_busy;
  logic                 src_b_busy;
  logic                 accept;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_vec[i] = (cnt[i] != '0);
      dec[i]      = (cnt[i] != '0) ? cnt[i] - 1'b1 : '0;
    end
    any_busy = |busy_vec;
  end

  // Old counts only: a producer never stalls on its own destination.
  assign src_a_busy = sb.src_a_used && (sb.src_a != '0) && (cnt[sb.src_a] != '0);
  assign src_b_busy = sb.src_b_used && (sb.src_b != '0) && (cnt[sb.src_b] != '0);
  assign sb.stall   = sb.issue_valid && !flush && (src_a_busy || src_b_busy);

  assign accept = sb.issue_valid && sb.issue_wr_en && !sb.stall && !freeze && !flush
                  && (sb.issue_dst != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else if (!freeze) begin
      cnt[0] <= '0;
      // WAW keeps whichever wait is longer.
      for (int i = 1; i < NUM_REGS; i++) begin
        if (accept && (sb.issue_dst == REG_NUM_WIDTH'(i)) && (sb.issue_lat > dec[i]))
          cnt[i] <= sb.issue_lat;
        else
          cnt[i] <= dec[i];
      end
    end
  end

`ifdef SB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles <= '0;
      issue_count  <= '0;
    end else begin
      if (sb.stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (sb.issue_valid && !sb.stall && !freeze && !flush && (issue_count != '1))
        issue_count <= issue_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: the driver pushes expected outputs from a ready-time model, a monitor pops and compares.
module tb_hazard_scoreboard;

  localparam int RW = 5;
  localparam int NR = 32;
  localparam int CW = 3;

  typedef struct packed {
    logic          rst;
    logic          freeze;
    logic          flush;
    logic          valid;
    logic          wr;
    logic [RW-1:0] dst;
    logic [CW-1:0] lat;
    logic [RW-1:0] a;
    logic [RW-1:0] b;
    logic          au;
    logic          bu;
  } stim_t;

  typedef struct {
    logic          stall;
    logic [NR-1:0] busy;
    logic          any;
    int            sc;
    int            ic;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic freeze = 1'b0;
  logic flush = 1'b0;
  logic [NR-1:0] busy_vec;
  logic any_busy;
  logic [15:0] stall_cycles;
  logic [15:0] issue_count;

  hazard_scoreboard_if #(.REG_NUM_WIDTH(RW), .CNT_WIDTH(CW)) sb_if ();

  hazard_scoreboard #(.REG_NUM_WIDTH(RW), .NUM_REGS(NR), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .freeze   (freeze),
    .flush    (flush),
    .sb       (sb_if),
    .busy_vec (busy_vec),
`ifdef SB_STATS_EN
    .stall_cycles (stall_cycles),
    .issue_count  (issue_count),
`endif
    .any_busy (any_busy)
  );

`ifndef SB_STATS_EN
  initial begin
    stall_cycles = '0;
    issue_count  = '0;
  end
`endif

  always #5 clk = ~clk;

  // Model: a register is busy while the count of unfrozen edges is below its ready time.
  int unsigned active;
  int unsigned ready_at [NR];
  int          m_sc;
  int          m_ic;
  stim_t       cur;
  exp_t        q[$];
  int          vectors;
  int          errors;

  function automatic bit m_busy(logic [RW-1:0] r);
    return (r != 0) && (ready_at[r] > active);
  endfunction

  function automatic bit m_stall(stim_t s);
    return s.valid && !s.flush && ((s.au && m_busy(s.a)) || (s.bu && m_busy(s.b)));
  endfunction

  task automatic model_edge(input stim_t s);
    bit st;
    st = m_stall(s);
    if (!s.rst) begin
      for (int i = 0; i < NR; i++) ready_at[i] = active;
      m_sc = 0;
      m_ic = 0;
    end else begin
      if (st && m_sc < 65535) m_sc++;
      if (s.valid && !st && !s.freeze && !s.flush && m_ic < 65535) m_ic++;
      if (!s.freeze) begin
        active++;
        if (s.valid && s.wr && !st && !s.flush && s.dst != 0)
          if (active + s.lat > ready_at[s.dst]) ready_at[s.dst] = active + s.lat;
      end
    end
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    model_edge(cur);
    cur = s;
    rst                 = s.rst;
    freeze              = s.freeze;
    flush               = s.flush;
    sb_if.issue_valid   = s.valid;
    sb_if.issue_wr_en   = s.wr;
    sb_if.issue_dst     = s.dst;
    sb_if.issue_lat     = s.lat;
    sb_if.src_a         = s.a;
    sb_if.src_b         = s.b;
    sb_if.src_a_used    = s.au;
    sb_if.src_b_used    = s.bu;
    e.stall = m_stall(s);
    for (int i = 0; i < NR; i++) e.busy[i] = m_busy(RW'(i));
    e.any = |e.busy;
    e.sc  = m_sc;
    e.ic  = m_ic;
    q.push_back(e);
  endtask

  function automatic stim_t st(bit v, bit w, int d, int l, int a, bit au,
                               int b = 0, bit bu = 0, bit fz = 0, bit fl = 0, bit r = 1);
    stim_t s;
    s.rst = r; s.freeze = fz; s.flush = fl; s.valid = v; s.wr = w;
    s.dst = RW'(d); s.lat = CW'(l); s.a = RW'(a); s.b = RW'(b); s.au = au; s.bu = bu;
    return s;
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (sb_if.stall !== e.stall) begin
          errors++;
          $display("FAIL stall t=%0t got=%b exp=%b", $time, sb_if.stall, e.stall);
        end
        if (busy_vec !== e.busy) begin
          errors++;
          $display("FAIL busy_vec t=%0t got=%h exp=%h", $time, busy_vec, e.busy);
        end
        if (any_busy !== e.any) begin
          errors++;
          $display("FAIL any_busy t=%0t got=%b exp=%b", $time, any_busy, e.any);
        end
`ifdef SB_STATS_EN
        if (int'(stall_cycles) != e.sc) begin
          errors++;
          $display("FAIL stall_cycles t=%0t got=%0d exp=%0d", $time, stall_cycles, e.sc);
        end
        if (int'(issue_count) != e.ic) begin
          errors++;
          $display("FAIL issue_count t=%0t got=%0d exp=%0d", $time, issue_count, e.ic);
        end
`endif
      end
    end
  end

  initial begin
    stim_t s;
    int    guard;
    vectors = 0;
    errors  = 0;
    active  = 0;
    m_sc    = 0;
    m_ic    = 0;
    for (int i = 0; i < NR; i++) ready_at[i] = 0;
    sb_if.issue_valid = 0; sb_if.issue_wr_en = 0; sb_if.issue_dst = 0; sb_if.issue_lat = 0;
    sb_if.src_a = 0; sb_if.src_b = 0; sb_if.src_a_used = 0; sb_if.src_b_used = 0;
    cur = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset mid-countdown
    step(st(0, 0, 0, 0, 0, 0));
    step(st(1, 1, 5, 3, 0, 0));
    step(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(st(1, 0, 0, 0, 5, 1));
    step(st(0, 0, 0, 0, 0, 0));
    // Load-use
    step(st(1, 1, 5, 1, 0, 0));
    repeat (3) step(st(1, 0, 0, 0, 5, 1));
    // Freeze extends the stall
    step(st(1, 1, 7, 3, 0, 0));
    step(st(1, 0, 0, 0, 7, 1));
    repeat (2) step(st(1, 0, 0, 0, 7, 1, 0, 0, 1));
    repeat (4) step(st(1, 0, 0, 0, 7, 1));
    // WAW keeps the longer wait
    step(st(1, 1, 3, 3, 0, 0));
    step(st(1, 1, 3, 1, 0, 0));
    repeat (4) step(st(1, 0, 0, 0, 0, 0, 3, 1));
    // r0 never tracked; flush suppresses stall
    step(st(1, 1, 0, 3, 0, 0));
    step(st(1, 1, 5, 3, 0, 0));
    step(st(1, 0, 0, 0, 5, 1, 0, 0, 0, 1));
    repeat (4) step(st(1, 0, 0, 0, 5, 1));
    // Self-dependency: same-cycle producer and source
    step(st(1, 1, 6, 2, 6, 1));
    repeat (3) step(st(1, 0, 0, 0, 6, 1));

    for (int n = 0; n < 3000; n++) begin
      s.rst    = ($urandom_range(0, 99) != 0);
      s.freeze = ($urandom_range(0, 4) == 0);
      s.flush  = ($urandom_range(0, 9) == 0);
      s.valid  = ($urandom_range(0, 3) != 0);
      s.wr     = 1'($urandom_range(0, 1));
      s.dst    = RW'($urandom_range(0, 7));
      s.lat    = CW'($urandom_range(0, 7));
      s.a      = RW'($urandom_range(0, 7));
      s.b      = RW'($urandom_range(0, 7));
      s.au     = 1'($urandom_range(0, 1));
      s.bu     = 1'($urandom_range(0, 1));
      step(s);
    end

    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
